// File: rtl/async_event_sched.sv
// ---------------------------------------------------------------------------
// async_event_sched
// Serialises N asynchronous request lines into one valid/ready event stream.
// Each line has a two-flop synchroniser, a third flop for edge detection, and
// a pending bit. A round-robin arbiter loads pending lines into a single
// output slot that carries the line index.
//
// Optional feature macro: ASYNC_EVT_BOTHEDGE_EN
//   defined   -> both rising and falling edges produce events
//   undefined -> rising edges only
//
// Ports:
//   CLK_I        system clock, rising edge
//   RST_N_I      synchronous active-low reset
//   REQ_I[N]     asynchronous request lines
//   EVT_VALID_O  output slot holds an event
//   EVT_READY_I  consumer accepts the event when valid & ready
//   EVT_IDX_O    index of the line that produced the event
//   PEND_O[N]    registered pending bits
//   OVF_O[N]     sticky per-line overflow flags
//   OVF_CLR_I    clears all overflow flags (a same-cycle set wins)
//
// REQ_I to r_s1 is an asynchronous crossing; constrain it as timing-ignore.
// ---------------------------------------------------------------------------
module async_event_sched #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic            CLK_I,
  input  logic            RST_N_I,
  input  logic [N-1:0]    REQ_I,
  output logic            EVT_VALID_O,
  input  logic            EVT_READY_I,
  output logic [IDXW-1:0] EVT_IDX_O,
  output logic [N-1:0]    PEND_O,
  output logic [N-1:0]    OVF_O,
  input  logic            OVF_CLR_I
);

  // Synchroniser stages; s1/s2 must stay discrete flops placed together.
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic [N-1:0] r_s1;
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic [N-1:0] r_s2;
  logic [N-1:0]    r_s3;

  logic [N-1:0]    r_pend;
  logic [N-1:0]    r_ovf;
  logic [IDXW-1:0] r_ptr;
  logic            r_valid;
  logic [IDXW-1:0] r_idx;

  logic [N-1:0]    w_edge;
  logic            w_found;
  logic [IDXW-1:0] w_winner;
  logic [IDXW-1:0] w_cand;
  logic            w_load;
  logic [N-1:0]    w_load_mask;
  logic [N-1:0]    w_ovf_set;
  logic [IDXW-1:0] w_ptr_next;

  // Modulo-N increment of an index by an offset smaller than N.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return IDXW'(s);
  endfunction

  // Edge detector on the synchronised level.
`ifdef ASYNC_EVT_BOTHEDGE_EN
  assign w_edge = r_s2 ^ r_s3;
`else
  assign w_edge = r_s2 & ~r_s3;
`endif

  // Round-robin search: first pending bit at ptr, ptr+1, ... wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = wrap_add(r_ptr, k);
      if (!w_found && r_pend[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Slot is loadable when empty or being drained this cycle.
  assign w_load      = (!r_valid || EVT_READY_I) && w_found;
  assign w_load_mask = w_load ? (N'(1) << w_winner) : '0;
  // A new edge on a line that stays pending would be lost.
  assign w_ovf_set   = w_edge & r_pend & ~w_load_mask;
  assign w_ptr_next  = wrap_add(w_winner, 1);

  // Synchroniser and edge history.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= REQ_I;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Pending bits, overflow flags, arbiter pointer and output slot.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      r_pend  <= '0;
      r_ovf   <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      // Edge on the line being loaded re-queues it instead of overflowing.
      r_pend <= (r_pend & ~w_load_mask) | w_edge;
      r_ovf  <= (OVF_CLR_I ? '0 : r_ovf) | w_ovf_set;
      if (w_load) begin
        r_valid <= 1'b1;
        r_idx   <= w_winner;
        r_ptr   <= w_ptr_next;
      end else if (EVT_READY_I) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign EVT_VALID_O = r_valid;
  assign EVT_IDX_O   = r_idx;
  assign PEND_O      = r_pend;
  assign OVF_O       = r_ovf;

endmodule

// File: tb/tb_async_event_sched.sv
module tb_async_event_sched;

  localparam int unsigned N    = 4;
  localparam int unsigned IDXW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic            ready = 1'b0;
  logic            ovf_clr = 1'b0;
  logic            evt_valid;
  logic [IDXW-1:0] evt_idx;
  logic [N-1:0]    pend;
  logic [N-1:0]    ovf;

  async_event_sched #(.N(N), .IDXW(IDXW)) dut (
    .CLK_I      (clk),
    .RST_N_I    (rst_n),
    .REQ_I      (req),
    .EVT_VALID_O(evt_valid),
    .EVT_READY_I(ready),
    .EVT_IDX_O  (evt_idx),
    .PEND_O     (pend),
    .OVF_O      (ovf),
    .OVF_CLR_I  (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [IDXW-1:0] exp_q[$];
  int ev_cnt[N];
  logic [IDXW-1:0] mon_exp;

  typedef struct packed {
    logic [N-1:0]           req;
    logic [2:0]             n;
    logic [3:0][IDXW-1:0]   order;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ncyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    tick();
  endtask

  // Scoreboard: every accepted handshake pops the next expected index.
  always @(negedge clk) begin
    if (rst_n && evt_valid && ready) begin
      ev_cnt[evt_idx]++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got idx %0d expected none", evt_idx);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event_idx", 32'(evt_idx), 32'(mon_exp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    for (int i = 0; i < int'(N); i++) ev_cnt[i] = 0;

    // ptr sequence: 3 -> 0 -> 0 -> 0 -> 0 -> 3 -> 1 -> 1
    vecs[0] = '{req: 4'b1000, n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[1] = '{req: 4'b1111, n: 3'd4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[2] = '{req: 4'b1111, n: 3'd4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[3] = '{req: 4'b1010, n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd1}};
    vecs[4] = '{req: 4'b0101, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd0}};
    vecs[5] = '{req: 4'b1001, n: 3'd2, order: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[6] = '{req: 4'b0011, n: 3'd2, order: {2'd0, 2'd0, 2'd0, 2'd1}};

    // Reset state
    ncyc(3);
    @(negedge clk);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_idx",   32'(evt_idx),   32'd0);
    check("rst_pend",  32'(pend),      32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    ncyc(3);

    // Latency: valid exactly at capture edge + 3, for one cycle
    req = 4'b0100;
    exp_q.push_back(2'd2);
    for (int c = 1; c <= 5; c++) begin
      tick();
      @(negedge clk);
      check($sformatf("lat_valid_c%0d", c), 32'(evt_valid), 32'(c == 4));
      if (c == 4) check("lat_idx", 32'(evt_idx), 32'd2);
    end
    check("lat_pend", 32'(pend), 32'd0);
    check("lat_ovf",  32'(ovf),  32'd0);
    tick();
    req = '0;
    drain("lat");

    // Table-driven bursts through the round-robin arbiter
    for (int v = 0; v < 7; v++) begin
      tick();
      req = vecs[v].req;
      for (int j = 0; j < int'(vecs[v].n); j++) exp_q.push_back(vecs[v].order[j]);
      ncyc(6);
      req = '0;
      drain($sformatf("vec%0d", v));
      @(negedge clk);
      check($sformatf("vec%0d_pend", v), 32'(pend), 32'd0);
      check($sformatf("vec%0d_ovf", v),  32'(ovf),  32'd0);
    end

    // Back-pressure hold, re-queue, overflow and clear
    tick();
    ready = 1'b0;
    req = 4'b0010;
    exp_q.push_back(2'd1);
    ncyc(5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(evt_valid), 32'd1);
      check("hold_idx",   32'(evt_idx),   32'd1);
      tick();
    end
    req = '0;
    ncyc(3);
    req = 4'b0010;
    exp_q.push_back(2'd1);
    ncyc(5);
    @(negedge clk);
    check("requeue_pend", 32'(pend), 32'b0010);
    check("requeue_ovf",  32'(ovf),  32'd0);
    tick();
    req = '0;
    ncyc(3);
    req = 4'b0010;
    ncyc(5);
    @(negedge clk);
    check("ovf_set",  32'(ovf),  32'b0010);
    check("ovf_pend", 32'(pend), 32'b0010);
    tick();
    req = '0;
    ready = 1'b1;
    drain("ovf");
    @(negedge clk);
    check("ovf_sticky", 32'(ovf), 32'b0010);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", 32'(ovf), 32'd0);

    // Edge on line 3 in the same cycle line 3 is loaded
    for (int i = 0; i < int'(N); i++) ev_cnt[i] = 0;
    tick();
    ready = 1'b0;
    req = 4'b0001;
    exp_q.push_back(2'd0);
    ncyc(5);
    req = 4'b1001;
    exp_q.push_back(2'd3);
    ncyc(5);
    @(negedge clk);
    check("same_pre_pend", 32'(pend), 32'b1000);
    tick();
    req = 4'b0001;
    ncyc(3);
    req = 4'b1001;
    exp_q.push_back(2'd3);
    tick();
    tick();
    ready = 1'b1;
    tick();
    @(negedge clk);
    check("same_pend",  32'(pend),      32'b1000);
    check("same_ovf",   32'(ovf),       32'd0);
    check("same_valid", 32'(evt_valid), 32'd1);
    check("same_idx",   32'(evt_idx),   32'd3);
    tick();
    req = '0;
    drain("same");
    check("same_idx3_count", 32'(ev_cnt[3]), 32'd2);
    check("same_ovf_end",    32'(ovf),       32'd0);

    // Mid-operation reset discards slot and pending
    tick();
    ready = 1'b0;
    req = 4'b0001;
    ncyc(5);
    req = 4'b0111;
    ncyc(5);
    @(negedge clk);
    check("prerst_pend",  32'(pend),      32'b0110);
    check("prerst_valid", 32'(evt_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    req = '0;
    tick();
    @(negedge clk);
    check("midrst_valid", 32'(evt_valid), 32'd0);
    check("midrst_idx",   32'(evt_idx),   32'd0);
    check("midrst_pend",  32'(pend),      32'd0);
    check("midrst_ovf",   32'(ovf),       32'd0);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      if (evt_valid) seen++;
    end
    check("postrst_quiet", 32'(seen), 32'd0);

    // Level held then released: one event, or two when both edges count
    for (int i = 0; i < int'(N); i++) ev_cnt[i] = 0;
    tick();
    req = 4'b0001;
    exp_q.push_back(2'd0);
`ifdef ASYNC_EVT_BOTHEDGE_EN
    exp_q.push_back(2'd0);
`endif
    ncyc(5);
    req = '0;
    drain("level");
`ifdef ASYNC_EVT_BOTHEDGE_EN
    check("level_count", 32'(ev_cnt[0]), 32'd2);
`else
    check("level_count", 32'(ev_cnt[0]), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
